bram_row_fetcher: RTL and testbench
===================================

# bram_row_fetcher

Reads a contiguous run of wide rows from the second port of the shared row BRAM and presents each row on a valid/ready interface. It is the downstream consumer of the AXI-Stream-to-BRAM adapter: the adapter fills the BRAM one row at a time over AXI-Stream, and this block streams those rows at full width into the compute datapath. Read issue is credit-limited against a 4-entry row FIFO, so back-pressure never drops or duplicates a row.

## Interface
- BRAM_DEPTH, 12: BRAM address width in bits.
- BRAM_WIDTH, 1152: row width in bits (36 words × 32).
- clk  in  1  clock for all logic; also drives the BRAM read port.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a fetch; ignored while busy=1.
- start_index  in  BRAM_DEPTH  first row address; sampled when start is accepted.
- row_count  in  BRAM_DEPTH+1  number of rows to fetch; sampled when start is accepted.
- abort  in  1  synchronous cancel of the current fetch.
- busy  out  1  high from the cycle after start is accepted until done or abort completes.
- done  out  1  one-cycle pulse after the final row handshake.
- bram_en  out  1  read enable for the BRAM port.
- bram_addr  out  BRAM_DEPTH  read address.
- bram_dout  in  BRAM_WIDTH  BRAM read data.
- row_valid  out  1  row_data holds a valid row.
- row_data  out  BRAM_WIDTH  row payload, driven from the FIFO head.
- row_last  out  1  asserted together with the final row of the fetch.
- row_ready  in  1  consumer accepts the row.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE → ISSUE: start=1 and row_count≠0. Latch start_index into the address counter and row_count into both the issue counter and the delivery counter.
- start=1 with row_count=0: no BRAM access; done pulses in the next cycle; the FSM stays in IDLE.
- ISSUE: assert bram_en with bram_addr = current address only when (fifo_count + inflight) < 4. Each issue increments the address (wrapping modulo 2^BRAM_DEPTH, so 0xFFF → 0x000) and decrements the issue counter. When the issue counter reaches 0, go to DRAIN.
- Read latency L is 1 cycle (see Configuration). A shift register of L valid bits tracks in-flight reads; inflight is its popcount. Returning data is written into the FIFO.
- FIFO: 4 entries × (BRAM_WIDTH+1), where the extra bit is the last flag. The last flag is set on the read whose issue counter was 1 at issue time. Because credits cap occupancy, the FIFO can never overflow.
- A handshake is row_valid & row_ready. Each handshake pops the FIFO and decrements the delivery counter.
- DRAIN → IDLE: on the handshake where the delivery counter goes 1 → 0. done pulses in the following cycle, and busy falls in that same cycle.
- abort (any non-IDLE state): next cycle the FSM is in IDLE, the FIFO is flushed, in-flight valid bits are cleared, bram_en=0, row_valid=0, and done is not pulsed. Late BRAM data is discarded.
- abort and start in the same cycle while in IDLE: start wins.
- start while busy=1: ignored, with no effect on the counters.

## Timing
- Reset values: busy=0, done=0, bram_en=0, bram_addr=0, row_valid=0, row_last=0, row_data=0. Reset also empties the FIFO and clears all counters. Assertion takes effect immediately; mid-fetch reset abandons the fetch and produces no done.
- Start latency: start high in cycle 0 → bram_en=1 at start_index in cycle 1 → data on bram_dout in cycle 1+L → FIFO write at the end of that cycle → row_valid in cycle 2+L (cycle 3 at L=1).
- With row_ready held at 1, one row per cycle is delivered after the first. N rows: last handshake in cycle N+1+L, done in cycle N+2+L.
- row_data and row_last are stable while row_valid=1 and row_ready=0.
- bram_en is registered; bram_addr is meaningful only while bram_en=1 and otherwise holds its last value.

## Configuration
- BRAM_ROW_FETCH_OREG_EN defined: the BRAM output register is in use, so L=2. The in-flight shift register is 2 deep, and first row_valid arrives in cycle 4 after start.
- Not defined: L=1 and the in-flight shift register is 1 deep.
- In both builds the FIFO depth stays 4 and full throughput (1 row/cycle) is sustained.

## Test plan
- start_index=0x010, row_count=3, row_ready=1, BRAM row i holds pattern i → bram_addr 0x010, 0x011, 0x012 in cycles 1–3; rows arrive in cycles 3–5 with row_last on 0x012; done in cycle 6.
- start_index=0xFFE, row_count=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001; data arrives in order.
- row_count=8, row_ready low for cycles 3–12 → bram_en stops after 4 rows are buffered or in flight; rows are delivered in order after release; no loss or duplication.
- row_count=0 → no bram_en; done pulses in cycle 1.
- abort in cycle 4 of a 10-row fetch with row_ready=1 → row_valid=0 and busy=0 in cycle 5; no done; a new start in cycle 6 fetches correctly.
- rst asserted mid-fetch → all outputs return to reset values immediately; no spurious rows after release.

Source files
------------

// File: rtl/bram_row_fetcher_if.sv
// bram_row_fetcher_if: BRAM read port plus the valid/ready row stream of the row fetcher.
// master = fetcher side, slave = BRAM and row consumer side.
interface bram_row_fetcher_if #(
  parameter int BRAM_DEPTH = 12,
  parameter int BRAM_WIDTH = 1152
);
  logic                  bram_en;
  logic [BRAM_DEPTH-1:0] bram_addr;
  logic [BRAM_WIDTH-1:0] bram_dout;
  logic                  row_valid;
  logic [BRAM_WIDTH-1:0] row_data;
  logic                  row_last;
  logic                  row_ready;

  modport master (
    output bram_en, bram_addr, row_valid, row_data, row_last,
    input  bram_dout, row_ready
  );

  modport slave (
    input  bram_en, bram_addr, row_valid, row_data, row_last,
    output bram_dout, row_ready
  );
endinterface

// File: rtl/bram_row_fetcher.sv
// bram_row_fetcher: streams a run of BRAM rows through a 4-entry credit-limited row FIFO.
// Define BRAM_ROW_FETCH_OREG_EN when the BRAM output register is enabled (read latency 2).
module bram_row_fetcher #(
  parameter int BRAM_DEPTH = 12,
  parameter int BRAM_WIDTH = 1152
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BRAM_DEPTH-1:0] start_index,
  input  logic [BRAM_DEPTH:0]   row_count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  bram_row_fetcher_if.master    bus
);

`ifdef BRAM_ROW_FETCH_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FIFO_DEPTH = 4;
  localparam logic [BRAM_DEPTH:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_next;
  logic [BRAM_DEPTH-1:0] addr_cnt, addr_q, issue_addr;
  logic [BRAM_DEPTH:0]   issue_cnt, deliv_cnt;
  logic                  en_q, last_q, done_q;
  logic [LAT-1:0]        rd_vld, rd_last;
  logic [BRAM_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [BRAM_WIDTH:0]   fifo_head;
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  logic                  fifo_wr, row_valid, handshake, credit_ok;
  logic                  issue, issue_last, accept, flush, done_next;
  logic [3:0]            outstanding;

  assign row_valid = (fifo_count != 3'd0);
  assign handshake = row_valid & bus.row_ready;
  assign fifo_wr   = rd_vld[LAT-1];
  assign fifo_head = fifo_mem[rd_ptr];

  // Rows buffered, in the BRAM pipe or just requested; a row popped this cycle frees its slot.
  always_comb begin
    outstanding = {1'b0, fifo_count} + {3'b000, en_q};
    for (int i = 0; i < LAT; i++) outstanding = outstanding + {3'b000, rd_vld[i]};
    credit_ok = outstanding < (4'(FIFO_DEPTH) + {3'b000, handshake});
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    accept     = 1'b0;
    flush      = 1'b0;
    done_next  = 1'b0;
    issue_addr = addr_cnt;
    case (state)
      IDLE: begin
        issue_addr = start_index;
        if (start) begin
          if (row_count == '0) begin
            done_next = 1'b1;
          end else begin
            accept     = 1'b1;
            issue      = 1'b1;
            issue_last = (row_count == ONE);
            state_next = (row_count == ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (credit_ok) begin
          issue      = 1'b1;
          issue_last = (issue_cnt == ONE);
          if (issue_cnt == ONE) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (handshake && deliv_cnt == ONE) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt   <= '0;
      addr_q     <= '0;
      issue_cnt  <= '0;
      deliv_cnt  <= '0;
      en_q       <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld     <= '0;
      rd_last    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      done_q <= done_next;
      en_q   <= issue;
      last_q <= issue_last;
      if (issue) begin
        addr_q   <= issue_addr;
        addr_cnt <= issue_addr + 1'b1;
      end
      if (accept) begin
        issue_cnt <= row_count - ONE;
        deliv_cnt <= row_count;
      end else begin
        if (issue)     issue_cnt <= issue_cnt - ONE;
        if (handshake) deliv_cnt <= deliv_cnt - ONE;
      end
      // Clearing the valid pipe on abort drops any BRAM data still on its way back.
      if (flush) begin
        rd_vld     <= '0;
        rd_last    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        rd_vld[0]  <= en_q;
        rd_last[0] <= last_q;
        for (int i = 1; i < LAT; i++) begin
          rd_vld[i]  <= rd_vld[i-1];
          rd_last[i] <= rd_last[i-1];
        end
        if (fifo_wr)   wr_ptr <= wr_ptr + 2'd1;
        if (handshake) rd_ptr <= rd_ptr + 2'd1;
        fifo_count <= fifo_count + {2'b00, fifo_wr} - {2'b00, handshake};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr && !flush) fifo_mem[wr_ptr] <= {rd_last[LAT-1], bus.bram_dout};
  end

  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign bus.bram_en   = en_q;
  assign bus.bram_addr = addr_q;
  assign bus.row_valid = row_valid;
  assign bus.row_data  = row_valid ? fifo_head[BRAM_WIDTH-1:0] : '0;
  assign bus.row_last  = row_valid & fifo_head[BRAM_WIDTH];

endmodule

// File: tb/tb_bram_row_fetcher.sv
// tb_bram_row_fetcher: directed fetches checked against a row-queue model and a behavioural BRAM.
module tb_bram_row_fetcher;
  localparam int DEPTH = 12;
  localparam int WIDTH = 1152;
`ifdef BRAM_ROW_FETCH_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start, abort;
  logic [DEPTH-1:0] start_index;
  logic [DEPTH:0]   row_count;
  logic             busy, done;

  bram_row_fetcher_if #(.BRAM_DEPTH(DEPTH), .BRAM_WIDTH(WIDTH)) bus ();

  bram_row_fetcher #(.BRAM_DEPTH(DEPTH), .BRAM_WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_index(start_index),
    .row_count(row_count), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int cyc = 0, start_cyc = 0;
  int issued = 0, delivered = 0, done_cnt = 0;
  int done_cyc = -1, first_en_cyc = -1, first_valid_cyc = -1;
  logic [DEPTH-1:0] exp_issue_q[$];
  logic [DEPTH:0]   exp_row_q[$];
  logic [DEPTH:0]   exp_entry;
  logic [WIDTH-1:0] exp_pat, held_data;
  logic             held_last, stall_prev = 1'b0;
  logic [31:0]      last_row_word = '0;

  // Row contents: every 32-bit word encodes the row address and its word index.
  function automatic logic [WIDTH-1:0] pattern(input logic [DEPTH-1:0] a);
    logic [WIDTH-1:0] p;
    logic [7:0]       k8;
    p = '0;
    for (int k = 0; k < WIDTH/32; k++) begin
      k8 = 8'(k);
      p[k*32 +: 32] = {a, 4'h5, k8, a[7:0] ^ k8};
    end
    return p;
  endfunction

  logic [WIDTH-1:0] bram_q1, bram_q2;
  always @(posedge clk) begin
    if (bus.bram_en) bram_q1 <= pattern(bus.bram_addr);
    bram_q2 <= bram_q1;
  end
  assign bus.bram_dout = (LAT == 2) ? bram_q2 : bram_q1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bram_en) begin
        issued++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (exp_issue_q.size() == 0) checkOutput("unexpected_bram_en", 1, 0);
        else checkOutput("bram_addr", 64'(bus.bram_addr), 64'(exp_issue_q.pop_front()));
        checkOutput("credit_bound", 64'((issued - delivered) <= 4), 1);
      end
      if (stall_prev && bus.row_valid) begin
        checkOutput("stall_data_stable", 64'(bus.row_data === held_data), 1);
        checkOutput("stall_last_stable", 64'(bus.row_last), 64'(held_last));
      end
      if (bus.row_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.row_valid && bus.row_ready) begin
        delivered++;
        if (exp_row_q.size() == 0) begin
          checkOutput("spurious_row", 1, 0);
        end else begin
          exp_entry = exp_row_q.pop_front();
          exp_pat   = pattern(exp_entry[DEPTH-1:0]);
          checkOutput("row_data_low", bus.row_data[63:0], exp_pat[63:0]);
          checkOutput("row_data_full", 64'(bus.row_data === exp_pat), 1);
          checkOutput("row_last", 64'(bus.row_last), 64'(exp_entry[DEPTH]));
          if (bus.row_last) last_row_word = bus.row_data[31:0];
        end
      end
      stall_prev = bus.row_valid && !bus.row_ready;
      held_data  = bus.row_data;
      held_last  = bus.row_last;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        checkOutput("busy_low_at_done", 64'(busy), 0);
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flushModel();
    exp_issue_q.delete();
    exp_row_q.delete();
    issued     = 0;
    delivered  = 0;
    stall_prev = 1'b0;
  endtask

  task automatic applyStimulus(input logic [DEPTH-1:0] idx, input int n, input logic with_abort);
    logic [DEPTH-1:0] a;
    first_en_cyc    = -1;
    first_valid_cyc = -1;
    done_cyc        = -1;
    for (int i = 0; i < n; i++) begin
      a = idx + i[DEPTH-1:0];
      exp_issue_q.push_back(a);
      exp_row_q.push_back({(i == n - 1), a});
    end
    start       = 1'b1;
    abort       = with_abort;
    start_index = idx;
    row_count   = n[DEPTH:0];
    start_cyc   = cyc;
    stepCycle();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int base;
    int k;
    base = done_cnt;
    k    = 0;
    while (done_cnt == base && k < budget) begin
      stepCycle();
      k++;
    end
    if (done_cnt == base) checkOutput("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int dbase;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_index = '0; row_count = '0; bus.row_ready = 1'b1;
    #12;
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_bram_en", 64'(bus.bram_en), 0);
    checkOutput("rst_bram_addr", 64'(bus.bram_addr), 0);
    checkOutput("rst_row_valid", 64'(bus.row_valid), 0);
    checkOutput("rst_row_last", 64'(bus.row_last), 0);
    checkOutput("rst_row_data_zero", 64'(bus.row_data == '0), 1);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    $display("[TB] three rows from 0x010, a start while busy is ignored");
    applyStimulus(12'h010, 3, 1'b0);
    checkOutput("t1_busy_c1", 64'(busy), 1);
    start = 1'b1; start_index = 12'h3A0; row_count = 13'd5;
    stepCycle();
    start = 1'b0;
    waitDone(40);
    checkOutput("t1_first_en", 64'(first_en_cyc - start_cyc), 1);
    checkOutput("t1_first_valid", 64'(first_valid_cyc - start_cyc), 64'(2 + LAT));
    checkOutput("t1_done_cycle", 64'(done_cyc - start_cyc), 64'(3 + 2 + LAT));
    checkOutput("t1_last_word", 64'(last_row_word), 64'h0125_0012);
    checkOutput("t1_rows_left", 64'(exp_row_q.size()), 0);
    stepCycle();
    checkOutput("t1_busy_after", 64'(busy), 0);

    $display("[TB] four rows wrapping from 0xFFE");
    applyStimulus(12'hFFE, 4, 1'b0);
    waitDone(40);
    checkOutput("t2_done_cycle", 64'(done_cyc - start_cyc), 64'(4 + 2 + LAT));
    checkOutput("t2_last_word", 64'(last_row_word), 64'h0015_0001);
    checkOutput("t2_issue_left", 64'(exp_issue_q.size()), 0);
    checkOutput("t2_rows_left", 64'(exp_row_q.size()), 0);
    stepCycle();

    $display("[TB] eight rows with row_ready low in cycles 3-12");
    base = issued;
    applyStimulus(12'h100, 8, 1'b0);
    for (int rel = 1; rel <= 60 && done_cyc < 0; rel++) begin
      bus.row_ready = !(rel >= 3 && rel <= 12);
      if (rel == 13) checkOutput("t3_issued_while_stalled", 64'(issued - base), 4);
      stepCycle();
    end
    bus.row_ready = 1'b1;
    checkOutput("t3_done_cycle", 64'(done_cyc - start_cyc), 21);
    checkOutput("t3_rows_left", 64'(exp_row_q.size()), 0);
    stepCycle();

    $display("[TB] zero-length fetch");
    base = issued;
    applyStimulus(12'h055, 0, 1'b0);
    checkOutput("t4_done_c1", 64'(done), 1);
    checkOutput("t4_busy_c1", 64'(busy), 0);
    stepCycle();
    checkOutput("t4_done_c2", 64'(done), 0);
    stepCycle();
    stepCycle();
    checkOutput("t4_no_bram_en", 64'(issued - base), 0);

    $display("[TB] abort in cycle 4 of a ten-row fetch, then restart");
    applyStimulus(12'h300, 10, 1'b0);
    stepCycle();
    stepCycle();
    stepCycle();
    dbase = done_cnt;
    abort = 1'b1;
    stepCycle();
    abort = 1'b0;
    flushModel();
    checkOutput("t5_row_valid_c5", 64'(bus.row_valid), 0);
    checkOutput("t5_busy_c5", 64'(busy), 0);
    checkOutput("t5_bram_en_c5", 64'(bus.bram_en), 0);
    stepCycle();
    checkOutput("t5_no_done", 64'(done_cnt - dbase), 0);
    applyStimulus(12'h020, 2, 1'b0);
    waitDone(40);
    checkOutput("t5_restart_done", 64'(done_cyc - start_cyc), 64'(2 + 2 + LAT));
    checkOutput("t5_rows_left", 64'(exp_row_q.size()), 0);
    stepCycle();

    $display("[TB] reset in the middle of a fetch");
    dbase = done_cnt;
    applyStimulus(12'h400, 6, 1'b0);
    stepCycle();
    stepCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_busy", 64'(busy), 0);
    checkOutput("t6_done", 64'(done), 0);
    checkOutput("t6_bram_en", 64'(bus.bram_en), 0);
    checkOutput("t6_bram_addr", 64'(bus.bram_addr), 0);
    checkOutput("t6_row_valid", 64'(bus.row_valid), 0);
    checkOutput("t6_row_last", 64'(bus.row_last), 0);
    checkOutput("t6_row_data_zero", 64'(bus.row_data == '0), 1);
    flushModel();
    stepCycle();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) stepCycle();
    checkOutput("t6_no_done", 64'(done_cnt - dbase), 0);

    $display("[TB] start and abort together while idle");
    applyStimulus(12'h7F0, 3, 1'b1);
    waitDone(40);
    checkOutput("t6_start_wins_done", 64'(done_cyc - start_cyc), 64'(3 + 2 + LAT));
    checkOutput("t6_rows_left", 64'(exp_row_q.size()), 0);
    stepCycle();
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
